// File: rtl/key_event_scheduler.sv
// Key event scheduler: decoder key events -> ordered make/break queue with typematic repeat.
// Auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise ev_repeat stays 0.
module key_event_scheduler #(
  parameter int FIFO_DEPTH   = 8,
  parameter int DELAY_CYCLES = 50000000,
  parameter int RATE_CYCLES  = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [8:0]                    last_change,
  input  logic [511:0]                  key_down,
  input  logic                          ev_ready,
  output logic                          ev_valid,
  output logic [8:0]                    ev_code,
  output logic                          ev_make,
  output logic                          ev_repeat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       rpt;
    logic       make;
    logic [8:0] code;
  } ev_t;

  ev_t             mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  ev_t             head, fresh_entry, rep_entry, wr_data;
  logic            fresh, pop, can_wr, wr_fresh, wr_rep, wr_en;

  assign head       = mem[rd_ptr];
  assign ev_valid   = (count != '0);
  assign ev_code    = head.code;
  assign ev_make    = head.make;
  assign ev_repeat  = head.rpt;
  assign fifo_count = count;

  assign fresh       = key_valid && (last_change != 9'd0);
  assign fresh_entry = '{rpt: 1'b0, make: key_down[last_change], code: last_change};
  assign pop         = ev_valid && ev_ready;
  // A slot freed by a same-cycle pop is usable immediately.
  assign can_wr      = (count < DEPTH_C) || pop;
  assign wr_fresh    = fresh && can_wr;
  assign wr_en       = wr_fresh || wr_rep;
  assign wr_data     = wr_fresh ? fresh_entry : rep_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fresh && !can_wr) overflow <= 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [CNT_W-1:0] DLY_LD  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LD = CNT_W'(RATE_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       rep_code;
  logic             rep_pend;
  logic             fresh_make;

  assign fresh_make = fresh && key_down[last_change];
  assign rep_entry  = '{rpt: 1'b1, make: 1'b1, code: rep_code};
  assign wr_rep     = !fresh && rep_pend && can_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rep_code <= '0;
      rep_pend <= 1'b0;
    end else if (fresh_make) begin
      // A new press restarts the delay even if its FIFO write was dropped.
      state    <= S_DELAY;
      cnt      <= DLY_LD;
      rep_code <= last_change;
      rep_pend <= 1'b0;
    end else if (state != S_IDLE && !key_down[rep_code]) begin
      state    <= S_IDLE;
      rep_pend <= 1'b0;
    end else if (state != S_IDLE) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (wr_rep) rep_pend <= 1'b0;
      end else begin
        // Expiry while a repeat is still pending simply leaves one pending.
        state    <= S_REPEAT;
        cnt      <= RATE_LD;
        rep_pend <= 1'b1;
      end
    end
  end
`else
  assign rep_entry = '0;
  assign wr_rep    = 1'b0;
`endif

endmodule
